panda_mem_arbiter: RTL and testbench

Shares a single memory bus port between the Panda instruction-fetch port and the load/store (data) port. Data accesses normally win; a streak counter guarantees fetch forward progress. At most one bus transaction is outstanding, and the block routes each response back to its owner. It sits between the core's IF/MEM stage memory interfaces and a single-ported memory or interconnect.

---
 rtl/panda_pkg.sv | 17 +
 rtl/panda_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_panda_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/panda_pkg.sv
// Shared types for the Panda core memory-side blocks.
package panda_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_WAIT_INSTR = 2'd1,
        ARB_WAIT_DATA  = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_INSTR = 1'b0,
        ARB_OWNER_DATA  = 1'b1
    } arb_owner_e;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/panda_mem_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store, data first,
// with a streak counter that forces a fetch grant after MaxDataStreak data wins.
//
// state          | meaning
// ARB_IDLE       | nothing outstanding on the bus
// ARB_WAIT_INSTR | one response owed to the fetch port
// ARB_WAIT_DATA  | one response owed to the load/store port
module panda_mem_arbiter
    import panda_pkg::*;
#(
    parameter int MaxDataStreak = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int SW = $clog2(MaxDataStreak + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MaxDataStreak);

    arb_state_e    state_q, state_d;
    logic          hold_q, hold_d;
    arb_owner_e    held_q, held_d;
    logic [SW-1:0] streak_q, streak_d;

    logic          window;
    arb_owner_e    sel;
    logic          sel_req;
    logic          bus_req;
    logic          grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            hold_q   <= 1'b0;
            held_q   <= ARB_OWNER_INSTR;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            held_q   <= held_d;
            streak_q <= streak_d;
        end
    end

    // A response arriving this cycle frees the bus, so a new address phase may overlap it.
    always_comb begin
        window = (state_q == ARB_IDLE) || bus_rvalid_i;
        if (hold_q) begin
            sel = held_q;
        end else if (data_req_i && !(instr_req_i && (streak_q == STREAK_MAX))) begin
            sel = ARB_OWNER_DATA;
        end else begin
            sel = ARB_OWNER_INSTR;
        end
        sel_req = (sel == ARB_OWNER_DATA) ? data_req_i : instr_req_i;
        bus_req = window && sel_req;
        grant   = bus_req && bus_gnt_i;
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        held_d   = held_q;
        streak_d = streak_q;
        if (grant) begin
            state_d = (sel == ARB_OWNER_DATA) ? ARB_WAIT_DATA : ARB_WAIT_INSTR;
            hold_d  = 1'b0;
            if ((sel == ARB_OWNER_DATA) && instr_req_i) begin
                streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
            end else begin
                streak_d = '0;
            end
        end else begin
            // Pin the selection so the address phase stays stable until accepted.
            if (bus_req) begin
                hold_d = 1'b1;
                held_d = sel;
            end
            if ((state_q != ARB_IDLE) && bus_rvalid_i) begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_comb begin
        instr_gnt_o    = 1'b0;
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = '0;
        data_gnt_o     = 1'b0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = '0;
        bus_req_o      = 1'b0;
        bus_we_o       = 1'b0;
        bus_be_o       = '0;
        bus_addr_o     = '0;
        bus_wdata_o    = '0;
        if (!rst_i) begin
            bus_req_o = bus_req;
            if (bus_req) begin
                if (sel == ARB_OWNER_DATA) begin
                    bus_we_o    = data_we_i;
                    bus_be_o    = data_be_i;
                    bus_addr_o  = data_addr_i;
                    bus_wdata_o = data_wdata_i;
                end else begin
                    bus_be_o    = FETCH_BE;
                    bus_addr_o  = instr_addr_i;
                end
            end
            instr_gnt_o = grant && (sel == ARB_OWNER_INSTR);
            data_gnt_o  = grant && (sel == ARB_OWNER_DATA);
            if ((state_q == ARB_WAIT_INSTR) && bus_rvalid_i) begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = bus_rdata_i;
            end
            if ((state_q == ARB_WAIT_DATA) && bus_rvalid_i) begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = bus_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Directed and randomized checks of panda_mem_arbiter against a transaction-level model.
module tb_panda_mem_arbiter;

    localparam int MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    always #5 clk_i = ~clk_i;

    panda_mem_arbiter #(.MaxDataStreak(MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: who owes a response (0 none, 1 fetch, 2 data), who is pinned, data-win streak.
    int m_own    = 0;
    int m_pend   = 0;
    int m_streak = 0;
    int m_sel    = 0;
    bit m_breq   = 0;

    logic        e_bus_req, e_bus_we, e_ignt, e_dgnt, e_irv, e_drv;
    logic [3:0]  e_bus_be;
    logic [31:0] e_bus_addr, e_bus_wdata, e_irdata, e_drdata;

    bit wait_i = 0;
    bit wait_d = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit window;
        e_bus_req = 0; e_bus_we = 0; e_bus_be = 0; e_bus_addr = 0; e_bus_wdata = 0;
        e_ignt = 0; e_dgnt = 0; e_irv = 0; e_drv = 0; e_irdata = 0; e_drdata = 0;
        m_sel = 0;
        m_breq = 0;
        if (!rst_i) begin
            window = (m_own == 0) || bus_rvalid_i;
            if (m_pend != 0)                                          m_sel = m_pend;
            else if (data_req_i && !(instr_req_i && m_streak == MAX)) m_sel = 2;
            else if (instr_req_i)                                     m_sel = 1;
            m_breq = window && ((m_sel == 1 && instr_req_i) || (m_sel == 2 && data_req_i));
            if (m_breq) begin
                e_bus_req = 1;
                if (m_sel == 2) begin
                    e_bus_we = data_we_i; e_bus_be = data_be_i;
                    e_bus_addr = data_addr_i; e_bus_wdata = data_wdata_i;
                end else begin
                    e_bus_be = 4'hF; e_bus_addr = instr_addr_i;
                end
                e_ignt = bus_gnt_i && (m_sel == 1);
                e_dgnt = bus_gnt_i && (m_sel == 2);
            end
            if (bus_rvalid_i && m_own == 1) begin e_irv = 1; e_irdata = bus_rdata_i; end
            if (bus_rvalid_i && m_own == 2) begin e_drv = 1; e_drdata = bus_rdata_i; end
        end
    endtask

    task automatic model_update();
        if (rst_i) begin
            m_own = 0; m_pend = 0; m_streak = 0;
        end else if (m_breq && bus_gnt_i) begin
            m_own = m_sel;
            m_pend = 0;
            if (m_sel == 2 && instr_req_i) m_streak = (m_streak < MAX) ? m_streak + 1 : MAX;
            else m_streak = 0;
        end else begin
            if (m_breq) m_pend = m_sel;
            if (m_own != 0 && bus_rvalid_i) m_own = 0;
        end
    endtask

    // Settle inputs, then compare every output with the model.
    task automatic settle();
        #1;
        if (!rst_i) begin
            assert (!(wait_i && !instr_req_i) && !(wait_d && !data_req_i)) else begin
                tests_failed++;
                $error("FAIL proto_req_drop: instr_req %0b data_req %0b expected held", instr_req_i, data_req_i);
            end
        end
        model_eval();
        check("bus_req",      bus_req_o,      e_bus_req);
        check("bus_we",       bus_we_o,       e_bus_we);
        check("bus_be",       bus_be_o,       e_bus_be);
        check("bus_addr",     bus_addr_o,     e_bus_addr);
        check("bus_wdata",    bus_wdata_o,    e_bus_wdata);
        check("instr_gnt",    instr_gnt_o,    e_ignt);
        check("data_gnt",     data_gnt_o,     e_dgnt);
        check("instr_rvalid", instr_rvalid_o, e_irv);
        check("instr_rdata",  instr_rdata_o,  e_irdata);
        check("data_rvalid",  data_rvalid_o,  e_drv);
        check("data_rdata",   data_rdata_o,   e_drdata);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        wait_i = !rst_i && instr_req_i && !e_ignt;
        wait_d = !rst_i && data_req_i && !e_dgnt;
        #1;
    endtask

    logic starve_d [6];
    logic starve_i [6];

    initial begin
        rst_i = 1; instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h5555_AAAA;

        // Reset state: outputs held at zero even with bus activity
        settle();
        check("rst_bus_req", bus_req_o, 1'b0);
        tick();
        settle();
        tick();
        rst_i = 0; bus_rvalid_i = 0;
        settle();
        tick();

        // Fetch only
        instr_req_i = 1; instr_addr_i = 32'h100; bus_gnt_i = 1;
        settle();
        check("fetch_gnt", instr_gnt_o, 1'b1);
        check("fetch_addr", bus_addr_o, 32'h100);
        check("fetch_be", bus_be_o, 4'hF);
        tick();
        instr_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF;
        settle();
        check("fetch_rvalid", instr_rvalid_o, 1'b1);
        check("fetch_rdata", instr_rdata_o, 32'hDEADBEEF);
        check("fetch_no_data_rvalid", data_rvalid_o, 1'b0);
        tick();
        bus_rvalid_i = 0;

        // Simultaneous requests, streak 0: data store wins
        instr_req_i = 1; instr_addr_i = 32'h104;
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h200; data_wdata_i = 32'h1234_5678;
        bus_gnt_i = 1;
        settle();
        check("sim_we", bus_we_o, 1'b1);
        check("sim_be", bus_be_o, 4'b0011);
        check("sim_instr_gnt", instr_gnt_o, 1'b0);
        check("sim_data_gnt", data_gnt_o, 1'b1);
        tick();
        data_req_i = 0; data_we_i = 0;
        settle();
        check("sim_wait_instr_gnt", instr_gnt_o, 1'b0);
        tick();
        // Back-to-back: data response and fetch grant together
        bus_rvalid_i = 1; bus_rdata_i = 32'h0;
        settle();
        check("b2b_data_rvalid", data_rvalid_o, 1'b1);
        check("b2b_instr_gnt", instr_gnt_o, 1'b1);
        check("b2b_bus_addr", bus_addr_o, 32'h104);
        tick();
        instr_req_i = 0; bus_rdata_i = 32'hCAFE_F00D;
        settle();
        check("b2b_instr_rvalid", instr_rvalid_o, 1'b1);
        check("b2b_instr_rdata", instr_rdata_o, 32'hCAFE_F00D);
        check("b2b_no_data_rvalid", data_rvalid_o, 1'b0);
        tick();
        bus_rvalid_i = 0;

        // Starvation guard with a 0-wait memory
        starve_d = '{1, 1, 1, 1, 0, 1};
        starve_i = '{0, 0, 0, 0, 1, 0};
        instr_req_i = 1; instr_addr_i = 32'h180;
        data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h280;
        bus_gnt_i = 1;
        for (int i = 0; i < 6; i++) begin
            bus_rvalid_i = (m_own != 0);
            bus_rdata_i = $urandom;
            settle();
            check($sformatf("starve_data_gnt_%0d", i), data_gnt_o, starve_d[i]);
            check($sformatf("starve_instr_gnt_%0d", i), instr_gnt_o, starve_i[i]);
            tick();
        end
        data_req_i = 0; bus_rvalid_i = 1;
        settle();
        check("starve_tail_instr_gnt", instr_gnt_o, 1'b1);
        tick();
        instr_req_i = 0;
        settle();
        tick();
        bus_rvalid_i = 0;
        settle();
        tick();

        // Hold: fetch pinned while the bus stalls and data arrives
        instr_req_i = 1; instr_addr_i = 32'h300; bus_gnt_i = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h400;
            end
            settle();
            check($sformatf("hold_addr_%0d", i), bus_addr_o, 32'h300);
            check($sformatf("hold_data_gnt_%0d", i), data_gnt_o, 1'b0);
            tick();
        end
        bus_gnt_i = 1;
        settle();
        check("hold_instr_gnt", instr_gnt_o, 1'b1);
        check("hold_data_gnt_final", data_gnt_o, 1'b0);
        tick();
        instr_req_i = 0; bus_rvalid_i = 1;
        settle();
        check("hold_then_data_gnt", data_gnt_o, 1'b1);
        tick();
        data_req_i = 0; bus_rvalid_i = 0;
        settle();
        tick();

        // Reset while a data response is owed
        rst_i = 1; instr_req_i = 1; data_req_i = 1; bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h7777_7777;
        settle();
        check("rst_mid_bus_req", bus_req_o, 1'b0);
        check("rst_mid_data_rvalid", data_rvalid_o, 1'b0);
        tick();
        rst_i = 0; instr_req_i = 0; data_req_i = 0;
        settle();
        check("post_rst_data_rvalid", data_rvalid_o, 1'b0);
        check("post_rst_instr_rvalid", instr_rvalid_o, 1'b0);
        tick();
        bus_rvalid_i = 0;

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            if (!wait_i) begin
                instr_req_i = $urandom_range(0, 1);
                instr_addr_i = $urandom;
            end
            if (!wait_d) begin
                data_req_i = $urandom_range(0, 1);
                data_we_i = $urandom_range(0, 1);
                data_be_i = 4'($urandom_range(0, 15));
                data_addr_i = $urandom;
                data_wdata_i = $urandom;
            end
            bus_gnt_i = ($urandom_range(0, 3) != 0);
            bus_rvalid_i = (m_own != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
            bus_rdata_i = $urandom;
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
